mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  N-channel request/acknowledge arbiter that multiplexes video fetch, CPU and DMA
//  masters onto one synchronous single-port memory. Successor to the fixed two-port
//  dpmem hookup in the top level.
//  Adds:
//   - a parametrised channel count;
//   - round-robin or fixed-priority mode;
//   - pipelined reads with per-channel return tagging.
// PARAMETERS
//  P_channels     4   number of requesting channels, 2..8
//  P_data_bits    8   data width
//  P_addr_bits    16  address width
//  P_mem_latency  1   cycles from O_mem_en to valid I_mem_rdata, 1..4
//  P_fixed_prio0  1   1: channel 0 always wins (video); others round-robin. 0: all round-robin
// PORTS
//  I_clock      in   1      system clock, all logic on rising edge
//  I_reset      in   1      asynchronous, active-low reset
//  I_req        in   N      per-channel request, held until acked
//  I_we         in   N      per-channel write enable (1 write, 0 read)
//  I_addr       in   N*A    packed addresses, channel k at [k*A +: A]
//  I_wdata      in   N*D    packed write data, channel k at [k*D +: D]
//  O_ack        out  N      one-hot, 1-cycle pulse: command issued
//  O_rvalid     out  N      one-hot, 1-cycle pulse: O_rdata belongs to that channel
//  O_rdata      out  D      shared read-data return bus
//  O_mem_en     out  1      memory access strobe
//  O_mem_we     out  1      memory write enable
//  O_mem_addr   out  A      memory address
//  O_mem_wdata  out  D      memory write data
//  I_mem_rdata  in   D      memory read data, P_mem_latency cycles after O_mem_en
// BEHAVIOUR
//  Reset (I_reset=0, async):
//   - all outputs 0; RR pointer = 0; return pipeline cleared.
//   - Reads in flight at reset never produce O_rvalid.
//  Arbitration: combinational over I_req in cycle t; winner registered.
//   - O_mem_* and O_ack[winner] assert in cycle t+1 (1-cycle issue latency).
//   - Max one grant per cycle; at most one O_ack bit high.
//  Fixed mode (P_fixed_prio0=1):
//   - I_req[0] wins unconditionally; RR pointer not advanced by ch0 grants.
//  Round-robin: search starts at ptr; after grant to ch k, ptr = (k+1) mod N.
//   - Wrap N-1 -> 0. Non-ch0 requester granted within N-1 grants.
//  Handshake:
//   - requester holds I_req/I_we/I_addr/I_wdata stable until its O_ack.
//   - O_ack and the winner's registered command are in the same cycle.
//   - Requester may keep I_req high after ack for back-to-back; it is re-arbitrated
//     (so each channel gets at most one grant per cycle and RR fairness applies).
//   - Arbiter must not re-grant the same channel in the cycle its ack is high.
//     Each channel gets at most every other cycle; different channels may be granted
//     in consecutive cycles. This avoids double-issue before the master sees ack.
//  Idle: no I_req -> O_mem_en=0; O_mem_addr/wdata/we hold last value.
//  Reads:
//   - tag shift register, P_mem_latency deep: {valid, channel id}.
//   - O_rvalid[id] and O_rdata = I_mem_rdata P_mem_latency cycles after O_mem_en.
//   - Returns strictly in issue order; pipeline fully overlapped, one read per cycle.
//  Writes: no O_rvalid. Write then read of the same address, issued in
//   consecutive cycles, returns the new data (memory is write-first).
//  I_req dropped without ack: legal; request simply disappears, no side effect.
// TESTING
//  1. Reset with I_req=4'b1111 -> all outputs 0; first ack after release is O_ack=0001 (fixed mode).
//  2. RR (P_fixed_prio0=0), I_req=1110 held -> ack order 0010, 0100, 1000, 0010; never two adjacent to same ch.
//  3. Ch2 write 0x1234<-0xA5, then read 0x1234, lat=2 -> O_rvalid=0100, O_rdata=0xA5, 2 cycles after read's O_mem_en.
//  4. Back-to-back reads ch1 @0x10, ch3 @0x20 (mem preloaded 0x11/0x22) -> consecutive O_rvalid 0010/0x11 then 1000/0x22.
//  5. Fixed mode, ch0 requests every other cycle, ch1..3 constant -> ch1..3 each acked within 6 cycles, rotating.
//  6. Reset asserted 1 cycle after a read issue (lat=3) -> no O_rvalid ever for that read; ptr back to 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel request/acknowledge arbiter in front of one synchronous
// single-port memory. It has a registered one-cycle issue path and optional fixed
// priority for channel 0. Read data returns in issue order and is tagged with the
// owning channel, P_mem_latency cycles after the strobe.
module mem_arbiter #(
  parameter int P_channels    = 4,
  parameter int P_data_bits   = 8,
  parameter int P_addr_bits   = 16,
  parameter int P_mem_latency = 1,
  parameter int P_fixed_prio0 = 1
) (
  input  logic                               I_clock,
  input  logic                               I_reset,
  input  logic [P_channels-1:0]              I_req,
  input  logic [P_channels-1:0]              I_we,
  input  logic [P_channels*P_addr_bits-1:0]  I_addr,
  input  logic [P_channels*P_data_bits-1:0]  I_wdata,
  output logic [P_channels-1:0]              O_ack,
  output logic [P_channels-1:0]              O_rvalid,
  output logic [P_data_bits-1:0]             O_rdata,
  output logic                               O_mem_en,
  output logic                               O_mem_we,
  output logic [P_addr_bits-1:0]             O_mem_addr,
  output logic [P_data_bits-1:0]             O_mem_wdata,
  input  logic [P_data_bits-1:0]             I_mem_rdata
);

  localparam int ID_BITS = (P_channels > 1) ? $clog2(P_channels) : 1;
  localparam logic [ID_BITS:0]   N_W    = (ID_BITS+1)'(P_channels);
  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(P_channels - 1);

  logic [ID_BITS-1:0]     ptr_reg;
  logic [ID_BITS-1:0]     issued_id_reg;
  logic [P_channels-1:0]  eligible;
  logic                   grant_valid;
  logic [ID_BITS-1:0]     grant_id;
  logic                   sel_we;
  logic [P_addr_bits-1:0] sel_addr;
  logic [P_data_bits-1:0] sel_wdata;
  logic [P_channels-1:0]  ack_next;

  logic                   tag_valid_reg [P_mem_latency];
  logic [ID_BITS-1:0]     tag_id_reg    [P_mem_latency];

  // A channel whose ack is high this cycle is not yet aware of it, so it sits out one round
  assign eligible = I_req & ~O_ack;

  // Winner selection: optional hard priority for channel 0, otherwise rotate from ptr_reg
  always_comb begin
    logic [ID_BITS:0] sum;
    grant_valid = 1'b0;
    grant_id    = '0;
    sum         = '0;
    if (P_fixed_prio0 != 0 && eligible[0]) begin
      grant_valid = 1'b1;
      grant_id    = '0;
    end else begin
      for (int i = 0; i < P_channels; i++) begin
        sum = {1'b0, ptr_reg} + (ID_BITS+1)'(i);
        if (sum >= N_W) sum = sum - N_W;
        if (!grant_valid && eligible[sum[ID_BITS-1:0]]) begin
          grant_valid = 1'b1;
          grant_id    = sum[ID_BITS-1:0];
        end
      end
    end
  end

  // Command mux and one-hot ack for the selected channel
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    ack_next  = '0;
    for (int k = 0; k < P_channels; k++) begin
      if (grant_id == ID_BITS'(k)) begin
        sel_we      = I_we[k];
        sel_addr    = I_addr[k*P_addr_bits +: P_addr_bits];
        sel_wdata   = I_wdata[k*P_data_bits +: P_data_bits];
        ack_next[k] = grant_valid;
      end
    end
  end

  // Register the winner's command and ack together; address/data hold while idle
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      O_ack         <= '0;
      O_mem_en      <= 1'b0;
      O_mem_we      <= 1'b0;
      O_mem_addr    <= '0;
      O_mem_wdata   <= '0;
      issued_id_reg <= '0;
      ptr_reg       <= '0;
    end else begin
      O_ack    <= ack_next;
      O_mem_en <= grant_valid;
      if (grant_valid) begin
        O_mem_we      <= sel_we;
        O_mem_addr    <= sel_addr;
        O_mem_wdata   <= sel_wdata;
        issued_id_reg <= grant_id;
        // Channel 0 grants in fixed mode leave the rotation untouched
        if (!(P_fixed_prio0 != 0 && grant_id == '0))
          ptr_reg <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // Read-tag shift register aligned with the memory latency; reset discards reads in flight
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      for (int i = 0; i < P_mem_latency; i++) begin
        tag_valid_reg[i] <= 1'b0;
        tag_id_reg[i]    <= '0;
      end
    end else begin
      for (int i = P_mem_latency - 1; i > 0; i--) begin
        tag_valid_reg[i] <= tag_valid_reg[i-1];
        tag_id_reg[i]    <= tag_id_reg[i-1];
      end
      tag_valid_reg[0] <= O_mem_en & ~O_mem_we;
      tag_id_reg[0]    <= issued_id_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < P_channels; gi++) begin : g_rvalid
      assign O_rvalid[gi] = tag_valid_reg[P_mem_latency-1] &&
                            (tag_id_reg[P_mem_latency-1] == ID_BITS'(gi));
    end
  endgenerate

  // Return bus carries memory data only while a tagged read is being delivered
  assign O_rdata = (|O_rvalid) ? I_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-priority instance (latency 3) and a
// round-robin instance (latency 2), each backed by a write-first memory model.
module tb_mem_arbiter;
  localparam int N = 4;
  localparam int D = 8;
  localparam int A = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   f_req = '0, f_we = '0, f_ack, f_rvalid;
  logic [N*A-1:0] f_addr = '0;
  logic [N*D-1:0] f_wdata = '0;
  logic [D-1:0]   f_rdata, f_mem_wdata, f_mem_rdata;
  logic           f_mem_en, f_mem_we;
  logic [A-1:0]   f_mem_addr;

  logic [N-1:0]   r_req = '0, r_we = '0, r_ack, r_rvalid;
  logic [N*A-1:0] r_addr = '0;
  logic [N*D-1:0] r_wdata = '0;
  logic [D-1:0]   r_rdata, r_mem_wdata, r_mem_rdata;
  logic           r_mem_en, r_mem_we;
  logic [A-1:0]   r_mem_addr;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.P_channels(N), .P_data_bits(D), .P_addr_bits(A),
                .P_mem_latency(3), .P_fixed_prio0(1)) dut_f (
    .I_clock(clk), .I_reset(rst_n), .I_req(f_req), .I_we(f_we), .I_addr(f_addr),
    .I_wdata(f_wdata), .O_ack(f_ack), .O_rvalid(f_rvalid), .O_rdata(f_rdata),
    .O_mem_en(f_mem_en), .O_mem_we(f_mem_we), .O_mem_addr(f_mem_addr),
    .O_mem_wdata(f_mem_wdata), .I_mem_rdata(f_mem_rdata));

  mem_arbiter #(.P_channels(N), .P_data_bits(D), .P_addr_bits(A),
                .P_mem_latency(2), .P_fixed_prio0(0)) dut_r (
    .I_clock(clk), .I_reset(rst_n), .I_req(r_req), .I_we(r_we), .I_addr(r_addr),
    .I_wdata(r_wdata), .O_ack(r_ack), .O_rvalid(r_rvalid), .O_rdata(r_rdata),
    .O_mem_en(r_mem_en), .O_mem_we(r_mem_we), .O_mem_addr(r_mem_addr),
    .O_mem_wdata(r_mem_wdata), .I_mem_rdata(r_mem_rdata));

  // Write-first synchronous memory models
  logic [D-1:0] fmem [0:65535];
  logic [D-1:0] f_pipe [0:2];
  always @(posedge clk) begin
    if (f_mem_en) begin
      if (f_mem_we) fmem[f_mem_addr] <= f_mem_wdata;
      f_pipe[0] <= f_mem_we ? f_mem_wdata : fmem[f_mem_addr];
    end
    f_pipe[1] <= f_pipe[0];
    f_pipe[2] <= f_pipe[1];
  end
  assign f_mem_rdata = f_pipe[2];

  logic [D-1:0] rmem [0:65535];
  logic [D-1:0] r_pipe [0:1];
  always @(posedge clk) begin
    if (r_mem_en) begin
      if (r_mem_we) rmem[r_mem_addr] <= r_mem_wdata;
      r_pipe[0] <= r_mem_we ? r_mem_wdata : rmem[r_mem_addr];
    end
    r_pipe[1] <= r_pipe[0];
  end
  assign r_mem_rdata = r_pipe[1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    f_req = '0; f_we = '0; r_req = '0; r_we = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    f_req = 4'b1111; f_we = 4'b0000;
    f_addr = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    step();
    step();
    checks++; if (f_ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", f_ack); end
    checks++; if (f_rvalid !== 4'b0000) begin failures++; $display("FAIL reset_rvalid got=%b exp=0000", f_rvalid); end
    checks++; if (f_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", f_rdata); end
    checks++; if (f_mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", f_mem_en); end
    checks++; if (f_mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", f_mem_we); end
    checks++; if (f_mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", f_mem_addr); end
    checks++; if (f_mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=00", f_mem_wdata); end
    rst_n = 1'b1;
    step();
    $display("reset release: ack=%b mem_addr=%h", f_ack, f_mem_addr);
    checks++; if (f_ack !== 4'b0001) begin failures++; $display("FAIL first_ack got=%b exp=0001", f_ack); end
    checks++; if (f_mem_en !== 1'b1) begin failures++; $display("FAIL first_mem_en got=%b exp=1", f_mem_en); end
    checks++; if (f_mem_addr !== 16'h1111) begin failures++; $display("FAIL first_mem_addr got=%h exp=1111", f_mem_addr); end
    f_req = '0;
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack [4];
    exp_ack = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
    do_reset();
    r_req = 4'b1110; r_we = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      $display("rr grant %0d: ack=%b", i, r_ack);
      checks++; if (r_ack !== exp_ack[i]) begin failures++; $display("FAIL rr_ack[%0d] got=%b exp=%b", i, r_ack, exp_ack[i]); end
    end
    r_req = '0;
    step(); step(); step();
  endtask

  task automatic test_write_read();
    do_reset();
    r_req = 4'b0100; r_we = 4'b0100;
    r_addr[2*A +: A] = 16'h1234; r_wdata[2*D +: D] = 8'hA5;
    step();
    $display("write ch2: ack=%b addr=%h wdata=%h", r_ack, r_mem_addr, r_mem_wdata);
    checks++; if (r_ack !== 4'b0100) begin failures++; $display("FAIL wr_ack got=%b exp=0100", r_ack); end
    checks++; if (r_mem_we !== 1'b1) begin failures++; $display("FAIL wr_mem_we got=%b exp=1", r_mem_we); end
    checks++; if (r_mem_addr !== 16'h1234) begin failures++; $display("FAIL wr_mem_addr got=%h exp=1234", r_mem_addr); end
    checks++; if (r_mem_wdata !== 8'hA5) begin failures++; $display("FAIL wr_mem_wdata got=%h exp=a5", r_mem_wdata); end
    r_we = 4'b0000;
    step();
    checks++; if (r_ack !== 4'b0000) begin failures++; $display("FAIL no_regrant_ack got=%b exp=0000", r_ack); end
    checks++; if (r_mem_en !== 1'b0) begin failures++; $display("FAIL no_regrant_en got=%b exp=0", r_mem_en); end
    step();
    $display("read ch2: ack=%b we=%b", r_ack, r_mem_we);
    checks++; if (r_ack !== 4'b0100) begin failures++; $display("FAIL rd_ack got=%b exp=0100", r_ack); end
    checks++; if (r_mem_we !== 1'b0) begin failures++; $display("FAIL rd_mem_we got=%b exp=0", r_mem_we); end
    checks++; if (r_rvalid !== 4'b0000) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=0000", r_rvalid); end
    r_req = '0;
    step();
    checks++; if (r_rvalid !== 4'b0000) begin failures++; $display("FAIL rd_early got=%b exp=0000", r_rvalid); end
    step();
    $display("return: rvalid=%b rdata=%h", r_rvalid, r_rdata);
    checks++; if (r_rvalid !== 4'b0100) begin failures++; $display("FAIL rd_rvalid got=%b exp=0100", r_rvalid); end
    checks++; if (r_rdata !== 8'hA5) begin failures++; $display("FAIL rd_rdata got=%h exp=a5", r_rdata); end
    // Write on ch2 followed immediately by a read of the same address on ch1
    r_req = 4'b0100; r_we = 4'b0100; r_wdata[2*D +: D] = 8'h5C;
    step();
    checks++; if (r_ack !== 4'b0100) begin failures++; $display("FAIL wf_wr_ack got=%b exp=0100", r_ack); end
    r_req = 4'b0010; r_we = 4'b0000; r_addr[1*A +: A] = 16'h1234;
    step();
    checks++; if (r_ack !== 4'b0010) begin failures++; $display("FAIL wf_rd_ack got=%b exp=0010", r_ack); end
    r_req = '0;
    step();
    checks++; if (r_mem_en !== 1'b0) begin failures++; $display("FAIL idle_en got=%b exp=0", r_mem_en); end
    checks++; if (r_mem_addr !== 16'h1234) begin failures++; $display("FAIL idle_hold_addr got=%h exp=1234", r_mem_addr); end
    step();
    $display("write-first return: rvalid=%b rdata=%h", r_rvalid, r_rdata);
    checks++; if (r_rvalid !== 4'b0010) begin failures++; $display("FAIL wf_rvalid got=%b exp=0010", r_rvalid); end
    checks++; if (r_rdata !== 8'h5C) begin failures++; $display("FAIL wf_rdata got=%h exp=5c", r_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    r_req = 4'b1010; r_we = 4'b1010;
    r_addr[1*A +: A] = 16'h0010; r_wdata[1*D +: D] = 8'h11;
    r_addr[3*A +: A] = 16'h0020; r_wdata[3*D +: D] = 8'h22;
    step();
    r_req = 4'b1000;
    step();
    r_req = 4'b0000;
    step();
    r_req = 4'b1010; r_we = 4'b0000;
    step();
    checks++; if (r_ack !== 4'b0010) begin failures++; $display("FAIL b2b_ack1 got=%b exp=0010", r_ack); end
    r_req = 4'b1000;
    step();
    checks++; if (r_ack !== 4'b1000) begin failures++; $display("FAIL b2b_ack3 got=%b exp=1000", r_ack); end
    r_req = 4'b0000;
    step();
    $display("b2b return 1: rvalid=%b rdata=%h", r_rvalid, r_rdata);
    checks++; if (r_rvalid !== 4'b0010) begin failures++; $display("FAIL b2b_rvalid1 got=%b exp=0010", r_rvalid); end
    checks++; if (r_rdata !== 8'h11) begin failures++; $display("FAIL b2b_rdata1 got=%h exp=11", r_rdata); end
    step();
    $display("b2b return 2: rvalid=%b rdata=%h", r_rvalid, r_rdata);
    checks++; if (r_rvalid !== 4'b1000) begin failures++; $display("FAIL b2b_rvalid2 got=%b exp=1000", r_rvalid); end
    checks++; if (r_rdata !== 8'h22) begin failures++; $display("FAIL b2b_rdata2 got=%h exp=22", r_rdata); end
    step();
  endtask

  task automatic test_fixed_priority();
    logic [3:0] exp_ack [8];
    exp_ack = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    f_we = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      f_req = (k % 2 == 0) ? 4'b1111 : 4'b1110;
      step();
      $display("fixed cycle %0d: ack=%b", k, f_ack);
      checks++; if (f_ack !== exp_ack[k]) begin failures++; $display("FAIL fixed_ack[%0d] got=%b exp=%b", k, f_ack, exp_ack[k]); end
    end
    f_req = '0;
    step(); step(); step(); step();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    f_req = 4'b0010; f_we = 4'b0000; f_addr[1*A +: A] = 16'h0042;
    step();
    checks++; if (f_ack !== 4'b0010) begin failures++; $display("FAIL inflight_issue got=%b exp=0010", f_ack); end
    f_req = '0;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (f_mem_en !== 1'b0) begin failures++; $display("FAIL async_rst_en got=%b exp=0", f_mem_en); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (f_rvalid !== 4'b0000) begin failures++; $display("FAIL inflight_rvalid[%0d] got=%b exp=0000", i, f_rvalid); end
    end
    f_req = 4'b1110;
    step();
    $display("post-reset grant: ack=%b", f_ack);
    checks++; if (f_ack !== 4'b0010) begin failures++; $display("FAIL ptr_cleared got=%b exp=0010", f_ack); end
    f_req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_back_to_back();
    test_fixed_priority();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
